// File: rtl/dac_sched.sv
// Round-robin scheduler that turns channel-A/B update requests into dac_ctrl transactions.
// Handles the synchronous A+B update as a buffer write followed by an A-with-update write.
module dac_sched #(
    parameter logic [1:0]  RS_CH_A  = 2'b11,
    parameter logic [1:0]  RS_CH_B  = 2'b00,
    parameter logic [1:0]  RS_BUF   = 2'b01,
    parameter logic [1:0]  RS_A_UPD = 2'b10,
    parameter int unsigned TIMEOUT  = 512
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_req_a,
    input  logic [11:0] i_code_a,
    output logic        o_ack_a,
    input  logic        i_req_b,
    input  logic [11:0] i_code_b,
    output logic        o_ack_b,
    input  logic        i_sync,
    input  logic        i_spd,
    input  logic        i_pwr,
    output logic        o_DAC_en,
    output logic [11:0] o_DAC_Code,
    output logic [1:0]  o_DAC_RS,
    output logic        o_DAC_SPD,
    output logic        o_DAC_PWR,
    input  logic        i_DAC_Done,
    output logic        o_busy,
    output logic        o_timeout
);

    localparam int unsigned TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LAUNCH  = 3'd1,
        WAIT    = 3'd2,
        LAUNCH2 = 3'd3,
        WAIT2   = 3'd4,
        ACK     = 3'd5
    } state_e;

    state_e         state_q;
    logic [TW-1:0]  timer_q;
    logic           rr_b_q;
    logic           flip_q;
    logic           sync_q;
    logic           tgt_a_q;
    logic           tgt_b_q;
    logic [11:0]    code_a_q;
    logic           en_q;
    logic [11:0]    code_q;
    logic [1:0]     rs_q;
    logic           spd_q;
    logic           pwr_q;
    logic           ack_a_q;
    logic           ack_b_q;
    logic           busy_q;
    logic           timeout_q;

    logic want_sync_c;
    logic pick_a_c;
    logic pick_b_c;
    logic contend_c;
    logic expired_c;

    // Arbitration decode; only acted upon in IDLE
    always_comb begin
        want_sync_c = i_req_a & i_req_b & i_sync;
        contend_c   = i_req_a & i_req_b & ~i_sync;
        pick_a_c    = i_req_a & (~i_req_b | (contend_c & ~rr_b_q));
        pick_b_c    = i_req_b & (~i_req_a | (contend_c &  rr_b_q));
        expired_c   = (timer_q == TW'(TIMEOUT - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            rr_b_q    <= 1'b0;
            flip_q    <= 1'b0;
            sync_q    <= 1'b0;
            tgt_a_q   <= 1'b0;
            tgt_b_q   <= 1'b0;
            code_a_q  <= '0;
            en_q      <= 1'b0;
            code_q    <= '0;
            rs_q      <= '0;
            spd_q     <= 1'b0;
            pwr_q     <= 1'b0;
            ack_a_q   <= 1'b0;
            ack_b_q   <= 1'b0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            en_q      <= 1'b0;
            ack_a_q   <= 1'b0;
            ack_b_q   <= 1'b0;
            timeout_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (want_sync_c || pick_a_c || pick_b_c) begin
                        state_q  <= LAUNCH;
                        en_q     <= 1'b1;
                        busy_q   <= 1'b1;
                        spd_q    <= i_spd;
                        pwr_q    <= i_pwr;
                        sync_q   <= want_sync_c;
                        flip_q   <= contend_c;
                        tgt_a_q  <= pick_a_c | want_sync_c;
                        tgt_b_q  <= pick_b_c | want_sync_c;
                        code_a_q <= i_code_a;
                        code_q   <= pick_a_c ? i_code_a : i_code_b;
                        rs_q     <= want_sync_c ? RS_BUF : (pick_a_c ? RS_CH_A : RS_CH_B);
                    end
                end
                LAUNCH, LAUNCH2: begin
                    state_q <= (state_q == LAUNCH) ? WAIT : WAIT2;
                    timer_q <= '0;
                end
                WAIT, WAIT2: begin
                    // Done wins over an expiring timer in the same cycle
                    if (i_DAC_Done) begin
                        if (state_q == WAIT && sync_q) begin
                            state_q <= LAUNCH2;
                            en_q    <= 1'b1;
                            rs_q    <= RS_A_UPD;
                            code_q  <= code_a_q;
                        end else begin
                            state_q <= ACK;
                            ack_a_q <= tgt_a_q;
                            ack_b_q <= tgt_b_q;
                        end
                    end else if (expired_c) begin
                        state_q   <= IDLE;
                        busy_q    <= 1'b0;
                        timeout_q <= 1'b1;
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                ACK: begin
                    // Pointer moves only once a contended grant has completed
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    if (flip_q) begin
                        rr_b_q <= ~rr_b_q;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign o_ack_a    = ack_a_q;
    assign o_ack_b    = ack_b_q;
    assign o_DAC_en   = en_q;
    assign o_DAC_Code = code_q;
    assign o_DAC_RS   = rs_q;
    assign o_DAC_SPD  = spd_q;
    assign o_DAC_PWR  = pwr_q;
    assign o_busy     = busy_q;
    assign o_timeout  = timeout_q;

endmodule

// File: tb/tb_dac_sched.sv
// Directed bench for dac_sched: single, contended, alternating, sync, timeout and reset cases.
module tb_dac_sched;

    logic        clk;
    logic        rst_n;
    logic        i_req_a;
    logic [11:0] i_code_a;
    logic        o_ack_a;
    logic        i_req_b;
    logic [11:0] i_code_b;
    logic        o_ack_b;
    logic        i_sync;
    logic        i_spd;
    logic        i_pwr;
    logic        o_DAC_en;
    logic [11:0] o_DAC_Code;
    logic [1:0]  o_DAC_RS;
    logic        o_DAC_SPD;
    logic        o_DAC_PWR;
    logic        i_DAC_Done;
    logic        o_busy;
    logic        o_timeout;

    int n_chk;
    int n_bad;

    dac_sched dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_req_a    (i_req_a),
        .i_code_a   (i_code_a),
        .o_ack_a    (o_ack_a),
        .i_req_b    (i_req_b),
        .i_code_b   (i_code_b),
        .o_ack_b    (o_ack_b),
        .i_sync     (i_sync),
        .i_spd      (i_spd),
        .i_pwr      (i_pwr),
        .o_DAC_en   (o_DAC_en),
        .o_DAC_Code (o_DAC_Code),
        .o_DAC_RS   (o_DAC_RS),
        .o_DAC_SPD  (o_DAC_SPD),
        .o_DAC_PWR  (o_DAC_PWR),
        .i_DAC_Done (i_DAC_Done),
        .o_busy     (o_busy),
        .o_timeout  (o_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one cycle; sample point is 1ns after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        i_req_a    = 1'b0;
        i_req_b    = 1'b0;
        i_code_a   = '0;
        i_code_b   = '0;
        i_sync     = 1'b0;
        i_spd      = 1'b0;
        i_pwr      = 1'b0;
        i_DAC_Done = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic chk_launch(input string tag, input logic [1:0] rs, input logic [11:0] code);
        tick();
        chk({tag, "_en"},   32'(o_DAC_en),   32'd1);
        chk({tag, "_rs"},   32'(o_DAC_RS),   32'(rs));
        chk({tag, "_code"}, 32'(o_DAC_Code), 32'(code));
    endtask

    // Two WAIT cycles, then a Done pulse; returns sitting in the cycle after Done
    task automatic done_after_wait();
        tick();
        tick();
        i_DAC_Done = 1'b1;
        tick();
        i_DAC_Done = 1'b0;
    endtask

    task automatic chk_ack(input string tag, input logic ea, input logic eb);
        chk({tag, "_acka"}, 32'(o_ack_a), 32'(ea));
        chk({tag, "_ackb"}, 32'(o_ack_b), 32'(eb));
    endtask

    logic [1:0]  alt_rs   [4];
    logic [11:0] alt_code [4];
    logic        alt_a    [4];

    initial begin
        n_chk = 0;
        n_bad = 0;
        alt_rs   = '{2'b11, 2'b00, 2'b11, 2'b00};
        alt_code = '{12'hAAA, 12'hBBB, 12'hAAA, 12'hBBB};
        alt_a    = '{1'b1, 1'b0, 1'b1, 1'b0};

        do_reset();
        chk("rst_en",   32'(o_DAC_en),   32'd0);
        chk("rst_busy", 32'(o_busy),     32'd0);
        chk("rst_code", 32'(o_DAC_Code), 32'd0);
        chk("rst_misc", 32'({o_ack_a, o_ack_b, o_timeout, o_DAC_SPD, o_DAC_PWR, o_DAC_RS}), 32'd0);

        // Stray Done while idle is ignored
        i_DAC_Done = 1'b1;
        tick();
        i_DAC_Done = 1'b0;
        chk("idle_done_busy", 32'(o_busy), 32'd0);
        chk_ack("idle_done", 1'b0, 1'b0);

        // Single A request
        i_req_a  = 1'b1;
        i_code_a = 12'hC9B;
        i_spd    = 1'b1;
        chk_launch("a_only", 2'b11, 12'hC9B);
        chk("a_only_spd",  32'(o_DAC_SPD), 32'd1);
        chk("a_only_pwr",  32'(o_DAC_PWR), 32'd0);
        chk("a_only_busy", 32'(o_busy),    32'd1);
        i_spd = 1'b0;
        done_after_wait();
        chk_ack("a_only", 1'b1, 1'b0);
        i_req_a = 1'b0;
        tick();
        chk("a_only_idle_busy", 32'(o_busy),  32'd0);
        chk("a_only_ack_pulse", 32'(o_ack_a), 32'd0);

        // Contention without sync from reset: A first, then B at Done+3
        do_reset();
        i_req_a  = 1'b1;
        i_req_b  = 1'b1;
        i_code_a = 12'h111;
        i_code_b = 12'h222;
        chk_launch("cont1", 2'b11, 12'h111);
        done_after_wait();
        chk_ack("cont1", 1'b1, 1'b0);
        i_req_a = 1'b0;
        tick();
        chk("cont_gap_en", 32'(o_DAC_en), 32'd0);
        chk_launch("cont2", 2'b00, 12'h222);
        done_after_wait();
        chk_ack("cont2", 1'b0, 1'b1);
        i_req_b = 1'b0;

        // Both held continuously: grants alternate A,B,A,B
        do_reset();
        i_req_a  = 1'b1;
        i_req_b  = 1'b1;
        i_code_a = 12'hAAA;
        i_code_b = 12'hBBB;
        for (int k = 0; k < 4; k++) begin
            chk_launch($sformatf("alt%0d", k), alt_rs[k], alt_code[k]);
            done_after_wait();
            chk_ack($sformatf("alt%0d", k), alt_a[k], ~alt_a[k]);
            tick();
        end
        i_req_a = 1'b0;
        i_req_b = 1'b0;
        tick();
        tick();

        // Sync pair; code change after grant must be ignored
        do_reset();
        i_sync   = 1'b1;
        i_pwr    = 1'b1;
        i_req_a  = 1'b1;
        i_req_b  = 1'b1;
        i_code_a = 12'h123;
        i_code_b = 12'h456;
        chk_launch("sync1", 2'b01, 12'h456);
        chk("sync_pwr", 32'(o_DAC_PWR), 32'd1);
        i_code_a = 12'h000;
        tick();
        chk("sync_hold_code", 32'(o_DAC_Code), 32'h456);
        tick();
        i_DAC_Done = 1'b1;
        tick();
        i_DAC_Done = 1'b0;
        chk("sync2_en",   32'(o_DAC_en),   32'd1);
        chk("sync2_rs",   32'(o_DAC_RS),   32'd2);
        chk("sync2_code", 32'(o_DAC_Code), 32'h123);
        chk_ack("sync_mid", 1'b0, 1'b0);
        done_after_wait();
        chk_ack("sync", 1'b1, 1'b1);
        i_req_a = 1'b0;
        i_req_b = 1'b0;
        i_sync  = 1'b0;
        tick();
        chk("sync_idle_busy", 32'(o_busy), 32'd0);

        // Timeout: no Done, pulse after 512 WAIT cycles, then held req relaunches
        do_reset();
        i_req_a  = 1'b1;
        i_code_a = 12'h5A5;
        chk_launch("to", 2'b11, 12'h5A5);
        for (int k = 0; k < 512; k++) tick();
        chk("to_early",      32'(o_timeout), 32'd0);
        chk("to_early_busy", 32'(o_busy),    32'd1);
        tick();
        chk("to_pulse", 32'(o_timeout), 32'd1);
        chk("to_busy",  32'(o_busy),    32'd0);
        chk_ack("to", 1'b0, 1'b0);
        chk_launch("to_next", 2'b11, 12'h5A5);
        chk("to_pulse_end", 32'(o_timeout), 32'd0);
        done_after_wait();
        chk_ack("to_next", 1'b1, 1'b0);
        i_req_a = 1'b0;
        tick();

        // Async reset in WAIT clears outputs immediately
        do_reset();
        i_req_b  = 1'b1;
        i_code_b = 12'h7E1;
        i_spd    = 1'b1;
        chk_launch("mr", 2'b00, 12'h7E1);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("mr_busy", 32'(o_busy),     32'd0);
        chk("mr_code", 32'(o_DAC_Code), 32'd0);
        chk("mr_misc", 32'({o_DAC_en, o_DAC_RS, o_DAC_SPD, o_ack_b}), 32'd0);
        #2;
        rst_n = 1'b1;
        chk_launch("mr_relaunch", 2'b00, 12'h7E1);
        done_after_wait();
        chk_ack("mr_relaunch", 1'b0, 1'b1);
        i_req_b = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
